// File: rtl/cpu_instr_fetch.sv
// ----------------------------------------------------------------------------
// cpu_instr_fetch
//   Instruction fetch sequencer between a synchronous program memory and the
//   control FSM. It owns the program counter and reads one opcode per
//   instruction (1-cycle read latency). It presents the opcode on operation_o
//   and pulses exec_enable_o until the control FSM acknowledges with pc_inc_i.
//
//   Optional feature macro: FETCH_BREAKPOINT_EN (adds a PC breakpoint that
//   blocks run-initiated fetches; a step edge runs through it).
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   run_i          level: fetch and issue continuously while high
//   step_i         rising edge requests one instruction (honoured in IDLE)
//   pc_inc_i       acknowledge from the control FSM (sampled in ISSUE)
//   mem_rd_o       program memory read strobe
//   mem_addr_o     program memory address (= PC)
//   mem_data_i     read data, valid the cycle after mem_rd_o
//   operation_o    latched opcode
//   exec_enable_o  execute request to the control FSM
//   pc_o           current PC
//   busy_o         high whenever the sequencer is not IDLE
//   bp_en_i        (FETCH_BREAKPOINT_EN) breakpoint enable
//   bp_addr_i      (FETCH_BREAKPOINT_EN) breakpoint address
//   bp_hit_o       (FETCH_BREAKPOINT_EN) sticky breakpoint-hit flag
// ----------------------------------------------------------------------------
module cpu_instr_fetch #(
    parameter int unsigned PC_W = 8,
    parameter int unsigned OP_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            run_i,
    input  logic            step_i,
    input  logic            pc_inc_i,
    output logic            mem_rd_o,
    output logic [PC_W-1:0] mem_addr_o,
    input  logic [OP_W-1:0] mem_data_i,
    output logic [OP_W-1:0] operation_o,
    output logic            exec_enable_o,
    output logic [PC_W-1:0] pc_o,
    output logic            busy_o
`ifdef FETCH_BREAKPOINT_EN
    ,
    input  logic            bp_en_i,
    input  logic [PC_W-1:0] bp_addr_i,
    output logic            bp_hit_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_GAP,
        S_EXEC
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [OP_W-1:0] r_op;
    logic            r_step_q;
    logic            r_mem_rd;
    logic            r_exec_en;
    logic            r_busy;

    logic            w_step_edge;
    logic            w_run_fetch;   // run asks for a fetch and nothing blocks it
    logic            w_bp_trip;     // run asks for a fetch but the breakpoint stops it

    assign w_step_edge = step_i & ~r_step_q;

`ifdef FETCH_BREAKPOINT_EN
    logic r_bp_hit;
    logic w_run_go;
    logic w_bp_match;

    assign w_run_go    = run_i & ~r_bp_hit;
    assign w_bp_match  = bp_en_i && (r_pc == bp_addr_i);
    assign w_run_fetch = w_run_go & ~w_bp_match;
    assign w_bp_trip   = w_run_go & w_bp_match;
    assign bp_hit_o    = r_bp_hit;
`else
    assign w_run_fetch = run_i;
    assign w_bp_trip   = 1'b0;
`endif

    // Outputs are flops loaded together with the state transition, so they
    // always reflect the registered state and never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_op      <= '0;
            r_step_q  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_exec_en <= 1'b0;
            r_busy    <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
            r_bp_hit  <= 1'b0;
`endif
        end else begin
            r_step_q  <= step_i;
            r_mem_rd  <= 1'b0;
            r_exec_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A step edge coinciding with run still starts just one fetch.
                    if (w_step_edge) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                        r_busy   <= 1'b1;
`ifdef FETCH_BREAKPOINT_EN
                        r_bp_hit <= 1'b0;
`endif
                    end else if (w_run_fetch) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                        r_busy   <= 1'b1;
                    end else begin
                        r_busy   <= 1'b0;
                    end
`ifdef FETCH_BREAKPOINT_EN
                    if (!w_step_edge && w_bp_trip) begin
                        r_bp_hit <= 1'b1;
                    end
`endif
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_op      <= mem_data_i;
                    r_state   <= S_ISSUE;
                    r_exec_en <= 1'b1;
                end
                S_ISSUE: begin
                    if (pc_inc_i) begin
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    // One low cycle so the control FSM sees a fresh rising edge.
                    r_state   <= S_ISSUE;
                    r_exec_en <= 1'b1;
                end
                S_EXEC: begin
                    if (w_run_fetch) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
`ifdef FETCH_BREAKPOINT_EN
                    if (w_bp_trip) begin
                        r_bp_hit <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_o      = r_mem_rd;
    assign mem_addr_o    = r_pc;
    assign pc_o          = r_pc;
    assign operation_o   = r_op;
    assign exec_enable_o = r_exec_en;
    assign busy_o        = r_busy;

endmodule

// File: doc/cpu_instr_fetch.md
# cpu_instr_fetch

Instruction fetch sequencer that drives the control FSM's instruction interface. It reads 4-bit opcodes from a synchronous program memory at the program counter and presents each opcode on `operation_o`. It then raises `exec_enable_o` so the control FSM sees a rising edge, and advances the PC when the control FSM returns `pc_inc`. It sits between program memory and the control FSM and owns the PC.

## Interface
- `PC_W`, default 8: program counter and memory address width.
- `OP_W`, default 4: opcode width; matches the ALU op width.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset. Asynchronous assert, active-low.
- `run_i`  in  1  level. Fetch and issue continuously while high.
- `step_i`  in  1  a rising edge requests exactly one instruction. Edge-detected internally.
- `pc_inc_i`  in  1  from the control FSM; acknowledges the issued instruction.
- `mem_rd_o`  out  1  program memory read strobe.
- `mem_addr_o`  out  PC_W  program memory address; equals the PC register.
- `mem_data_i`  in  OP_W  read data, valid the cycle after `mem_rd_o`.
- `operation_o`  out  OP_W  latched opcode to the control FSM.
- `exec_enable_o`  out  1  execute request to the control FSM.
- `pc_o`  out  PC_W  current PC.
- `busy_o`  out  1  high when the state is not IDLE.

## Operation
- States and transitions:
  - **IDLE**: go to FETCH if `run_i` is high, or if a step edge is seen this cycle.
  - **FETCH**: `mem_rd_o` = 1. Go to WAIT.
  - **WAIT**: latch `mem_data_i` into the opcode register. Go to ISSUE.
  - **ISSUE**: `exec_enable_o` = 1. If `pc_inc_i` is high, go to EXEC; otherwise go to GAP.
  - **GAP**: `exec_enable_o` = 0. Go to ISSUE. This re-creates the rising edge for the control FSM.
  - **EXEC**: the opcode is held for the control FSM's execute cycle. Go to FETCH if `run_i` is high, otherwise go to IDLE.
- PC update:
  - The PC increments at the end of ISSUE when `pc_inc_i` is high.
  - The increment is modulo 2^PC_W: the PC wraps from 2^PC_W−1 to 0.
  - `pc_inc_i` is ignored in every other state.
- `operation_o` changes only at the end of WAIT. It is stable through ISSUE, GAP and EXEC.
- `exec_enable_o` and `mem_rd_o` are decoded from the registered state only and are glitch-free.
- Step handling:
  - A step edge is honoured only in IDLE. Edges that arrive while busy are dropped, not queued.
  - A step edge together with `run_i` high in IDLE starts one fetch, not two.
- Run handling:
  - Dropping `run_i` mid-instruction completes that instruction, then returns to IDLE.
  - Raising `run_i` mid-instruction continues from EXEC into FETCH.
- Reset values:
  - State = IDLE; PC = 0; opcode register = 0; step-edge register = 0.
  - All outputs = 0.
  - Reset mid-operation aborts the instruction immediately and does not increment the PC.

## Timing
- Memory read latency is 1 cycle: `mem_rd_o` in cycle n, data sampled in cycle n+1.
- With `run_i` sampled high in IDLE at cycle 0:
  - FETCH c1, WAIT c2, ISSUE c3, EXEC c4, FETCH c5.
  - `exec_enable_o` is high in c3 only.
- Steady-state throughput under `run_i` is 4 cycles per instruction.
- `pc_inc_i` is expected combinationally in the ISSUE cycle. Each missed acknowledge adds 2 cycles (GAP + ISSUE).
- `exec_enable_o` is never high in two consecutive cycles.

## Configuration
- `FETCH_BREAKPOINT_EN` defined:
  - Adds input `bp_en_i` (1), input `bp_addr_i` (PC_W) and output `bp_hit_o` (1).
  - In IDLE or EXEC, a run-initiated fetch with `bp_en_i` = 1 and PC == `bp_addr_i` does not fetch. Instead:
    - The state goes to (or stays in) IDLE.
    - `bp_hit_o` is set and is sticky.
    - Run is blocked while `bp_hit_o` = 1.
  - A step edge executes the instruction at the breakpoint address and clears `bp_hit_o`.
  - `bp_hit_o` resets to 0.
- `FETCH_BREAKPOINT_EN` not defined: these ports and the behaviour are absent.

## Test plan
- Reset, then step edge with memory[0]=0x3, `pc_inc_i` = start edge → `mem_rd_o` in c1 with addr 0; `operation_o` = 0x3 from c3; `exec_enable_o` for one cycle; `pc_o` = 1; back to IDLE, `busy_o` = 0.
- `run_i` held high for 12 cycles over memory 0x1, 0x2, 0x3 → exactly 3 `exec_enable_o` pulses spaced 4 cycles apart; `pc_o` = 3; `operation_o` stable through each EXEC.
- `pc_inc_i` withheld for the first 2 ISSUE cycles → `exec_enable_o` pattern 1,0,1,0,1; PC increments once, only on the acknowledged ISSUE.
- PC_W = 4, start at PC = 15 under run → fetch at addr 15, then wrap to 0 and fetch at addr 0.
- `rst_ni` low during ISSUE at PC = 5 → all outputs 0 immediately; PC = 0; no increment.
- `FETCH_BREAKPOINT_EN` defined, `bp_addr_i` = 2, run from 0 → 2 instructions issued, `bp_hit_o` = 1 with PC = 2; a step edge issues addr 2 and clears `bp_hit_o`.
